bram_reader: RTL and testbench

Read-side client for the 1024×8 block RAM's registered read port. It accepts a (start address, length) command, issues sequential reads against the RAM, and presents the bytes as a valid/ready stream with a last-byte flag. The block absorbs the RAM's one-cycle read latency so that downstream backpressure never loses or duplicates a byte. It sits between the RAM read port and any byte consumer, such as a UART transmitter or pixel pipeline.

---
 rtl/bram_reader_if.sv | 31 +++
 rtl/bram_reader.sv | 125 ++++++++++++
 tb/tb_bram_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_reader_if.sv
// Bundles the command, RAM read port and output stream of bram_reader.
// Ports: start/start_addr/length/busy/done (command), mem_rd_* (RAM read port),
//        out_valid/out_ready/out_data/out_last (byte stream).
// The master modport is the reader's view; slave is the view of whatever drives commands, models the RAM and consumes bytes.
interface bram_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) ();
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, start_addr, length, mem_rd_data, out_ready,
    output busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, start_addr, length, mem_rd_data, out_ready,
    input  busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bram_reader.sv
// Purpose: reads `length` sequential bytes from a registered-read block RAM and streams them out with a last flag.
// Latency: first byte valid 3 cycles after start; 1 byte/cycle sustained; done pulses the cycle after the last handshake.
// Backpressure: out_ready low stalls reads within one cycle; at most 2 bytes are held in the output buffer, none lost or repeated.
// Ports: clk, rst (async active-high); bus (bram_reader_if.master) carries the command, RAM read port and output stream.
module bram_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  bram_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;  // reads still to issue
  logic [ADDR_W:0]   out_cnt_q, out_cnt_d;      // bytes still to hand over
  logic              inflight_q, inflight_d;    // RAM data arrives this cycle
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic       pop;
  logic       rd_en;
  logic [1:0] pending;  // bytes buffered plus the one on its way from the RAM

  assign bus.out_valid   = (occ_q != 2'd0);
  assign bus.out_data    = buf_q[rd_ptr_q];
  assign bus.out_last    = bus.out_valid && (out_cnt_q == CNT_ONE);
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == FINISH);
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_addr_q;

  assign pop     = bus.out_valid & bus.out_ready;
  assign pending = occ_q + {1'b0, inflight_q};

  // Issue only if the byte would still have a buffer slot once it lands;
  // a pop this cycle frees one, so a full pipe can keep streaming.
  assign rd_en = (state_q == RUN) && (issue_cnt_q != '0) &&
                 ((pending < 2'd2) || ((pending == 2'd2) && pop));

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = rd_en;
    buf_d[0]    = buf_q[0];
    buf_d[1]    = buf_q[1];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rd_addr_d   = bus.start_addr;
          issue_cnt_d = bus.length;
          out_cnt_d   = bus.length;
          state_d     = (bus.length == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q - CNT_ONE;
          // Leave the address on the final read so it holds while idle.
          if (issue_cnt_q != CNT_ONE) begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
          end
        end
        if (pop) begin
          out_cnt_d = out_cnt_q - CNT_ONE;
          if (out_cnt_q == CNT_ONE) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (inflight_q) begin
      buf_d[wr_ptr_q] = bus.mem_rd_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

endmodule

// File: tb/tb_bram_reader.sv
// Scoreboard bench for bram_reader: commands push expected addresses and bytes,
// a negedge monitor pops and compares them, and timing is checked per command.
module tb_bram_reader;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  bram_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  // RAM model: mem[i] = i & 0xFF, registered read.
  logic [7:0] ram [1024];
  logic [7:0] rd_data_r;
  initial for (int i = 0; i < 1024; i++) ram[i] = i[7:0];
  always @(posedge clk) if (bus.mem_rd_en) rd_data_r <= ram[bus.mem_rd_addr];
  assign bus.mem_rd_data = rd_data_r;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [8:0] exp_q [$];
  int         addr_q [$];

  int hs_first, hs_last, done_cyc, done_cnt, rden_cnt, valid_cnt, busy_first, busy_cnt;
  int reads_out = 0;
  int pops_out = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_dat;
  logic       stall_last;
  logic [8:0] e;

  // out_ready driver: 0 = always high, 1 = random runs, 2 = held low
  int   rdy_mode = 0;
  int   run_left = 0;
  logic rv = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      2: bus.out_ready = 1'b0;
      default: begin
        if (run_left == 0) begin
          rv = !rv;
          run_left = rv ? $urandom_range(1, 3) : $urandom_range(1, 8);
        end else begin
          run_left--;
        end
        bus.out_ready = rv;
      end
    endcase
  end

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
      reads_out  = 0;
      pops_out   = 0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid_held", bus.out_valid, 1);
        chk("stall_data_held", bus.out_data, stall_dat);
        chk("stall_last_held", bus.out_last, stall_last);
      end
      if (bus.mem_rd_en) begin
        rden_cnt++;
        reads_out++;
        if (addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: addr %0d with no read pending (cycle %0d)", bus.mem_rd_addr, cyc);
        end else begin
          chk("rd_addr", bus.mem_rd_addr, addr_q.pop_front());
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        pops_out++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_byte: got %0d with no byte pending (cycle %0d)", bus.out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e[7:0]);
          chk("out_last", bus.out_last, e[8]);
        end
        if (hs_first < 0) hs_first = cyc;
        if (bus.out_last) hs_last = cyc;
      end
      if (bus.out_valid) valid_cnt++;
      if (bus.busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_at_done", bus.busy, 0);
      end
      chk("outstanding_le2", (reads_out - pops_out) <= 2, 1);
      stall_pend = bus.out_valid && !bus.out_ready;
      stall_dat  = bus.out_data;
      stall_last = bus.out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    hs_first = -1; hs_last = -1; done_cyc = -1; done_cnt = 0;
    rden_cnt = 0; valid_cnt = 0; busy_first = -1; busy_cnt = 0;
  endtask

  task automatic issue(input int a, input int len, output int c0);
    clear_stats();
    bus.start      = 1'b1;
    bus.start_addr = a[AW-1:0];
    bus.length     = len[AW:0];
    for (int i = 0; i < len; i++) begin
      int ad;
      ad = (a + i) % 1024;
      addr_q.push_back(ad);
      exp_q.push_back({(i == len - 1), ad[7:0]});
    end
    c0 = cyc;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic check_timing(input int c0, input int len, input int first_rel,
                              input int last_rel, input int done_rel);
    chk("busy_at_cycle1", busy_first - c0, 1);
    chk("first_byte_cycle", hs_first - c0, first_rel);
    chk("last_hs_cycle", hs_last - c0, last_rel);
    chk("done_cycle", done_cyc - c0, done_rel);
    chk("read_count", rden_cnt, len);
  endtask

  task automatic settle();
    step();
    chk("done_single_pulse", done_cnt, 1);
    chk("bytes_all_seen", exp_q.size(), 0);
    chk("reads_all_seen", addr_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_rd_addr"}, bus.mem_rd_addr, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_last"}, bus.out_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, d0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.length = '0;
    clear_stats();
    step(); step(); step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step(); step();

    // Basic stream, full throughput
    issue(0, 14, c0);
    wait_done(100);
    check_timing(c0, 14, 3, 16, 17);
    settle();

    // Address wrap
    issue(1020, 8, c0);
    wait_done(100);
    check_timing(c0, 8, 3, 10, 11);
    settle();

    // Random backpressure, plus a start pulse while busy that must be ignored
    rdy_mode = 1;
    issue(300, 20, c0);
    step(); step(); step(); step();
    bus.start = 1'b1;
    bus.start_addr = 10'd500;
    bus.length = 11'd3;
    step();
    bus.start = 1'b0;
    wait_done(600);
    chk("rand_read_count", rden_cnt, 20);
    chk("rand_done_after_last", done_cyc - hs_last, 1);
    settle();
    rdy_mode = 0;
    step();
    clear_stats();
    repeat (6) step();
    chk("idle_no_valid", valid_cnt, 0);
    chk("idle_no_read", rden_cnt, 0);

    // Zero length
    issue(7, 0, c0);
    wait_done(20);
    chk("len0_done_cycle", done_cyc - c0, 1);
    chk("len0_no_read", rden_cnt, 0);
    chk("len0_no_valid", valid_cnt, 0);
    chk("len0_no_busy", busy_cnt, 0);
    settle();

    // Reset mid-command with consumer stalled
    rdy_mode = 2;
    step();
    issue(50, 10, c0);
    step(); step();
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    addr_q.delete();
    clear_stats();
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("no_done_after_rst", done_cnt, 0);
    chk("idle_after_rst", bus.busy, 0);
    rdy_mode = 0;
    step();
    issue(100, 2, c0);
    wait_done(50);
    check_timing(c0, 2, 3, 4, 5);
    settle();

    // Back-to-back: second start in the cycle right after done
    issue(200, 4, c0);
    wait_done(50);
    check_timing(c0, 4, 3, 6, 7);
    d0 = done_cyc;
    issue(600, 5, c1);
    chk("b2b_start_after_done", c1 - d0, 1);
    wait_done(50);
    check_timing(c1, 5, 3, 7, 8);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
